// File: rtl/avalon_be_regbank_if.sv
// Avalon-MM slave bus bundle for the byte-enabled register bank.
interface avalon_be_regbank_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] avs_address;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic [BE_W-1:0]   avs_byteenable;
    logic              avs_read;
    logic [DATA_W-1:0] avs_readdata;
    logic              avs_readdatavalid;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_byteenable, avs_read,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_byteenable, avs_read,
        output avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/avalon_be_regbank.sv
// Bank of NUM_REGS byte-enabled registers behind an Avalon-MM slave, with a
// hardware-side write port and per-register host-write (dirty) flags.
module avalon_be_regbank #(
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          NUM_REGS  = 8,
    parameter int unsigned          ADDR_W    = 3,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
    input  logic                         clock,
    input  logic                         reset_n,
    avalon_be_regbank_if.slave           avs,
    input  logic [NUM_REGS-1:0]          hw_we,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata,
    input  logic [NUM_REGS-1:0]          hw_ack,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    output logic [NUM_REGS-1:0]          reg_dirty
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [DATA_W-1:0]   regs     [NUM_REGS];
    logic [DATA_W-1:0]   reg_nxt  [NUM_REGS];
    logic [NUM_REGS-1:0] bus_hit;
    logic [NUM_REGS-1:0] dirty_nxt;
    logic [DATA_W-1:0]   rd_data;
    logic [DATA_W-1:0]   readdata_q;
    logic                readdatavalid_q;

    // Next register values: hardware load first, then bus lanes overlay it so
    // the bus wins on enabled lanes and hardware fills the rest.
    always_comb begin
        bus_hit   = '0;
        dirty_nxt = reg_dirty & ~hw_ack;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            bus_hit[i] = avs.avs_write && (avs.avs_address == ADDR_W'(i));
            reg_nxt[i] = regs[i];
            if (hw_we[i]) begin
                reg_nxt[i] = hw_wdata[i*DATA_W +: DATA_W];
            end
            if (bus_hit[i]) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (avs.avs_byteenable[b]) begin
                        reg_nxt[i][b*8 +: 8] = avs.avs_writedata[b*8 +: 8];
                    end
                end
                if (|avs.avs_byteenable) begin
                    dirty_nxt[i] = 1'b1;
                end
            end
        end
    end

    // Read mux; unmatched (out-of-range) addresses return zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (avs.avs_address == ADDR_W'(i)) begin
                rd_data = regs[i];
            end
        end
    end

    // Flatten register contents onto the engine-side bus.
    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_W +: DATA_W] = regs[i];
        end
    end

    // State update; reset drops any read in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            reg_dirty       <= '0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= reg_nxt[i];
            end
            reg_dirty       <= dirty_nxt;
            readdatavalid_q <= avs.avs_read;
            if (avs.avs_read) begin
                readdata_q <= rd_data;
            end
        end
    end

    assign avs.avs_readdata      = readdata_q;
    assign avs.avs_readdatavalid = readdatavalid_q;
endmodule

// File: tb/tb_avalon_be_regbank.sv
// Directed, table-driven bench for avalon_be_regbank (NUM_REGS=6, DATA_W=32).
module tb_avalon_be_regbank;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 6;
    localparam int unsigned ADDR_W   = 3;

    logic                       clock;
    logic                       reset_n;
    logic [NUM_REGS-1:0]        hw_we;
    logic [NUM_REGS*DATA_W-1:0] hw_wdata;
    logic [NUM_REGS-1:0]        hw_ack;
    logic [NUM_REGS*DATA_W-1:0] reg_out;
    logic [NUM_REGS-1:0]        reg_dirty;

    int passed;
    int total;

    avalon_be_regbank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    avalon_be_regbank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .RESET_VAL('0)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .avs      (bus.slave),
        .hw_we    (hw_we),
        .hw_wdata (hw_wdata),
        .hw_ack   (hw_ack),
        .reg_out  (reg_out),
        .reg_dirty(reg_dirty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        rd;
        logic [5:0]  hwe;
        logic [31:0] hw_val;
        logic [5:0]  ack;
        int          chk;
        logic [31:0] exp_reg;
        logic [5:0]  exp_dirty;
        logic        exp_valid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic [2:0] addr, logic [31:0] wdata, logic [3:0] be,
                                logic rd, logic [5:0] hwe, logic [31:0] hw_val, logic [5:0] ack,
                                int chk, logic [31:0] exp_reg, logic [5:0] exp_dirty,
                                logic exp_valid, logic [31:0] exp_rdata);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.rd = rd;
        v.hwe = hwe; v.hw_val = hw_val; v.ack = ack; v.chk = chk;
        v.exp_reg = exp_reg; v.exp_dirty = exp_dirty;
        v.exp_valid = exp_valid; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.avs_address    = '0;
        bus.avs_write      = 1'b0;
        bus.avs_writedata  = '0;
        bus.avs_byteenable = '0;
        bus.avs_read       = 1'b0;
        hw_we              = '0;
        hw_wdata           = '0;
        hw_ack             = '0;
    endtask

    task automatic apply(input vec_t v);
        bus.avs_address    = v.addr;
        bus.avs_write      = v.wr;
        bus.avs_writedata  = v.wdata;
        bus.avs_byteenable = v.be;
        bus.avs_read       = v.rd;
        hw_we              = v.hwe;
        hw_wdata           = {NUM_REGS{v.hw_val}};
        hw_ack             = v.ack;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset_n = 1'b0;
        idle_inputs();

        //        wr addr wdata         be    rd hwe       hw_val        ack       chk exp_reg       exp_dirty  v  exp_rdata
        vecs.push_back(mk(1, 2, 32'hAABBCCDD, 4'hF, 0, 6'b000000, 32'h0,        6'b000000, 2, 32'hAABBCCDD, 6'b000100, 0, 32'h0));
        vecs.push_back(mk(1, 2, 32'h11223344, 4'h5, 0, 6'b000000, 32'h0,        6'b000000, 2, 32'hAA22CC44, 6'b000100, 0, 32'h0));
        vecs.push_back(mk(0, 2, 32'h0,        4'h0, 1, 6'b000000, 32'h0,        6'b000000, 2, 32'hAA22CC44, 6'b000100, 1, 32'hAA22CC44));
        vecs.push_back(mk(0, 0, 32'h0,        4'h0, 0, 6'b000000, 32'h0,        6'b000000, 2, 32'hAA22CC44, 6'b000100, 0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h5,        4'hF, 0, 6'b000000, 32'h0,        6'b000000, 1, 32'h5,        6'b000110, 0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h9,        4'hF, 1, 6'b000000, 32'h0,        6'b000000, 1, 32'h9,        6'b000110, 1, 32'h5));
        vecs.push_back(mk(0, 1, 32'h0,        4'h0, 1, 6'b000000, 32'h0,        6'b000000, 1, 32'h9,        6'b000110, 1, 32'h9));
        vecs.push_back(mk(0, 2, 32'h0,        4'h0, 1, 6'b000000, 32'h0,        6'b000000, 2, 32'hAA22CC44, 6'b000110, 1, 32'hAA22CC44));
        vecs.push_back(mk(1, 3, 32'hFFFFFFFF, 4'h8, 0, 6'b001000, 32'h12345678, 6'b000000, 3, 32'hFF345678, 6'b001110, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        4'h0, 0, 6'b001000, 32'hCAFEF00D, 6'b000000, 3, 32'hCAFEF00D, 6'b001110, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        4'h0, 0, 6'b000000, 32'h0,        6'b111111, 3, 32'hCAFEF00D, 6'b000000, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h00000001, 4'hF, 0, 6'b000000, 32'h0,        6'b000000, 0, 32'h00000001, 6'b000001, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'hFFFFFF02, 4'h1, 0, 6'b000000, 32'h0,        6'b000001, 0, 32'h00000002, 6'b000001, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        4'h0, 0, 6'b000000, 32'h0,        6'b000001, 0, 32'h00000002, 6'b000000, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0000DEAD, 4'h0, 0, 6'b000000, 32'h0,        6'b000000, 0, 32'h00000002, 6'b000000, 0, 32'h0));
        vecs.push_back(mk(1, 7, 32'hFFFFFFFF, 4'hF, 0, 6'b000000, 32'h0,        6'b000000, 5, 32'h0,        6'b000000, 0, 32'h0));
        vecs.push_back(mk(1, 6, 32'hFFFFFFFF, 4'hF, 0, 6'b000000, 32'h0,        6'b000000, 5, 32'h0,        6'b000000, 0, 32'h0));
        vecs.push_back(mk(0, 2, 32'h0,        4'h0, 1, 6'b000000, 32'h0,        6'b000000, 0, 32'h00000002, 6'b000000, 1, 32'hAA22CC44));
        vecs.push_back(mk(0, 7, 32'h0,        4'h0, 1, 6'b000000, 32'h0,        6'b000000, 0, 32'h00000002, 6'b000000, 1, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1, 6'b000000, 32'h0,        6'b000000, 0, 32'h00000002, 6'b000000, 1, 32'h00000002));

        // Reset state
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            check($sformatf("reset_reg%0d", i), 64'(reg_out[i*DATA_W +: DATA_W]), 64'h0);
        end
        check("reset_dirty", 64'(reg_dirty), 64'h0);
        check("reset_valid", 64'(bus.avs_readdatavalid), 64'h0);

        // Table-driven vectors, one bus cycle each
        for (int n = 0; n < vecs.size(); n++) begin
            apply(vecs[n]);
            @(posedge clock);
            #1;
            check($sformatf("v%0d_reg%0d", n, vecs[n].chk),
                  64'(reg_out[vecs[n].chk*DATA_W +: DATA_W]), 64'(vecs[n].exp_reg));
            check($sformatf("v%0d_dirty", n), 64'(reg_dirty), 64'(vecs[n].exp_dirty));
            check($sformatf("v%0d_valid", n), 64'(bus.avs_readdatavalid), 64'(vecs[n].exp_valid));
            if (vecs[n].exp_valid) begin
                check($sformatf("v%0d_rdata", n), 64'(bus.avs_readdata), 64'(vecs[n].exp_rdata));
            end
        end

        // Out-of-range writes must not have touched any in-range register
        idle_inputs();
        check("oor_reg1", 64'(reg_out[1*DATA_W +: DATA_W]), 64'h9);
        check("oor_reg2", 64'(reg_out[2*DATA_W +: DATA_W]), 64'hAA22CC44);
        check("oor_reg3", 64'(reg_out[3*DATA_W +: DATA_W]), 64'hCAFEF00D);
        check("oor_reg4", 64'(reg_out[4*DATA_W +: DATA_W]), 64'h0);

        // Reset cutting a read: read presented while reset is sampled
        bus.avs_address = 3'd2;
        bus.avs_read    = 1'b1;
        bus.avs_write   = 1'b1;
        bus.avs_writedata  = 32'h12121212;
        bus.avs_byteenable = 4'hF;
        reset_n         = 1'b0;
        @(posedge clock);
        #1;
        check("rstcut_valid", 64'(bus.avs_readdatavalid), 64'h0);
        check("rstcut_rdata", 64'(bus.avs_readdata), 64'h0);
        check("rstcut_reg2", 64'(reg_out[2*DATA_W +: DATA_W]), 64'h0);
        check("rstcut_dirty", 64'(reg_dirty), 64'h0);
        idle_inputs();
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("rstcut_valid_after", 64'(bus.avs_readdatavalid), 64'h0);
        check("rstcut_reg3", 64'(reg_out[3*DATA_W +: DATA_W]), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
